// File: rtl/imem_boot_loader.sv
// Streams a little-endian program (2-byte word count, then words) into IMEM and holds the core in reset until loaded.
// Latency: last byte of a word at edge k -> imem_we in cycle k+1; done/core_reset follow at edge k+2 for the final word.
// Backpressure: in_ready drops during the write cycle and in DONE/ERROR; upstream must hold in_valid/in_data until accepted.
module imem_boot_loader #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  err
);

    // Word count is 16 bits; one extra bit keeps the capacity compare from overflowing.
    localparam logic [16:0] MAX_N = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  xfer;
    logic [15:0]           hdr_n;

    assign xfer  = in_valid & in_ready_q;
    assign hdr_n = {in_data, cnt_q[7:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        case (state_q)
            S_HDR0: begin
                if (xfer) begin
                    cnt_d[7:0] = in_data;
                    state_d    = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    cnt_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, hdr_n} > MAX_N) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                        addr_d     = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d[8*byte_idx_q +: 8] = in_data;
                    byte_idx_d               = 2'(byte_idx_q + 2'd1);
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_WIDTH'(4);
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_DATA;
                    byte_idx_d = 2'd0;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_HDR0;
                    addr_d  = '0;
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_d = S_HDR0;
                end
            end
            default: state_d = S_HDR0;
        endcase
    end

    // Status flags are flops: release only once DONE has been held for a full cycle, re-assert on the start edge.
    always_comb begin
        in_ready_d   = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        imem_we_d    = (state_d == S_WRITE);
        done_d       = (state_q == S_DONE) && (state_d == S_DONE);
        core_reset_d = !done_d;
        err_d        = (state_q == S_ERROR) && (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_HDR0;
            cnt_q        <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            addr_q       <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            addr_q       <= addr_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
